// File: rtl/fuse_ctrl_init_seq.sv
// Power-on sequencer for the fuse controller: qualifies power-good, pulses partition
// init, waits for LC data valid with timeout/retry, and drives the lc_tx_t controls.
//
// state         | meaning
// --------------+------------------------------------------------------------
// ST_IDLE       | waiting for synchronized power-good
// ST_PWR_QUAL   | counting consecutive power-good cycles
// ST_INIT_PULSE | fc_partition_init asserted for INIT_PULSE_CYCLES
// ST_WAIT_VALID | waiting for otp_lc_data_o_valid, bounded by timeout
// ST_READY      | fuse controller ready; DFT / check-bypass requests honored
// ST_ERROR      | every attempt timed out; terminal until reset
// ST_ESCALATED  | escalation seen; terminal until reset
module fuse_ctrl_init_seq #(
  parameter int unsigned PWRGOOD_STABLE_CYCLES = 16,
  parameter int unsigned INIT_TIMEOUT_CYCLES   = 4096,
  parameter int unsigned MAX_RETRIES           = 2,
  parameter int unsigned INIT_PULSE_CYCLES     = 4
) (
  input  logic       core_clk,
  input  logic       core_rst,
  input  logic       cptra_pwrgood,
  input  logic       otp_lc_data_o_valid,
  input  logic       esc_req,
  input  logic       check_byp_req,
  input  logic       dft_en_req,
  output logic       fc_partition_init,
  output logic [3:0] lc_dft_en_i,
  output logic [3:0] lc_escalate_en_i,
  output logic [3:0] lc_check_byp_en_i,
  output logic       fuse_ctrl_rdy,
  output logic       init_err,
  output logic [2:0] retry_cnt
);

  localparam logic [3:0] LC_ON  = 4'b0101;
  localparam logic [3:0] LC_OFF = 4'b1010;

  localparam int unsigned TMO_W   = $clog2(INIT_TIMEOUT_CYCLES);
  localparam int unsigned SEQ_MAX = (PWRGOOD_STABLE_CYCLES > INIT_PULSE_CYCLES) ?
                                    PWRGOOD_STABLE_CYCLES : INIT_PULSE_CYCLES;
  localparam int unsigned SEQ_W   = (SEQ_MAX > 1) ? $clog2(SEQ_MAX) : 1;

  localparam logic [SEQ_W-1:0] QUAL_LOAD  = SEQ_W'(PWRGOOD_STABLE_CYCLES - 1);
  localparam logic [SEQ_W-1:0] PULSE_LOAD = SEQ_W'(INIT_PULSE_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LOAD   = TMO_W'(INIT_TIMEOUT_CYCLES - 1);
  localparam logic [2:0]       RETRY_MAX  = 3'(MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PWR_QUAL,
    ST_INIT_PULSE,
    ST_WAIT_VALID,
    ST_READY,
    ST_ERROR,
    ST_ESCALATED
  } state_e;

  state_e             state_q, state_d;
  logic               pwr_meta_q, pwr_sync_q;
  logic [SEQ_W-1:0]   seq_cnt_q, seq_cnt_d;
  logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [2:0]         retry_q, retry_d;
  logic               fc_init_q, fc_init_d;
  logic               rdy_q, rdy_d;
  logic               err_q, err_d;
  logic [3:0]         dft_q, dft_d;
  logic [3:0]         esc_q, esc_d;
  logic [3:0]         byp_q, byp_d;

  always_comb begin
    state_d   = state_q;
    seq_cnt_d = seq_cnt_q;
    tmo_cnt_d = tmo_cnt_q;
    retry_d   = retry_q;
    fc_init_d = fc_init_q;
    rdy_d     = rdy_q;
    err_d     = err_q;
    dft_d     = dft_q;
    esc_d     = esc_q;
    byp_d     = byp_q;

    if (esc_req) begin
      state_d   = ST_ESCALATED;
      esc_d     = LC_ON;
      dft_d     = LC_OFF;
      byp_d     = LC_OFF;
      fc_init_d = 1'b0;
      rdy_d     = 1'b0;
    end else if (!pwr_sync_q && (state_q inside {ST_PWR_QUAL, ST_INIT_PULSE,
                                                 ST_WAIT_VALID, ST_READY})) begin
      // Power loss restarts the whole bring-up from scratch.
      state_d   = ST_IDLE;
      fc_init_d = 1'b0;
      rdy_d     = 1'b0;
      retry_d   = 3'd0;
      dft_d     = LC_OFF;
      byp_d     = LC_OFF;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pwr_sync_q) begin
            state_d   = ST_PWR_QUAL;
            seq_cnt_d = QUAL_LOAD;
          end
        end
        ST_PWR_QUAL: begin
          if (seq_cnt_q == '0) begin
            state_d   = ST_INIT_PULSE;
            seq_cnt_d = PULSE_LOAD;
            fc_init_d = 1'b1;
          end else begin
            seq_cnt_d = seq_cnt_q - SEQ_W'(1);
          end
        end
        ST_INIT_PULSE: begin
          if (seq_cnt_q == '0) begin
            state_d   = ST_WAIT_VALID;
            tmo_cnt_d = TMO_LOAD;
            fc_init_d = 1'b0;
          end else begin
            seq_cnt_d = seq_cnt_q - SEQ_W'(1);
          end
        end
        ST_WAIT_VALID: begin
          if (otp_lc_data_o_valid) begin
            state_d = ST_READY;
            rdy_d   = 1'b1;
          end else if (tmo_cnt_q == '0) begin
            if (retry_q < RETRY_MAX) begin
              state_d   = ST_INIT_PULSE;
              retry_d   = retry_q + 3'd1;
              seq_cnt_d = PULSE_LOAD;
              fc_init_d = 1'b1;
            end else begin
              state_d = ST_ERROR;
              err_d   = 1'b1;
            end
          end else begin
            tmo_cnt_d = tmo_cnt_q - TMO_W'(1);
          end
        end
        ST_READY: begin
          dft_d = dft_en_req    ? LC_ON : LC_OFF;
          byp_d = check_byp_req ? LC_ON : LC_OFF;
        end
        ST_ERROR, ST_ESCALATED: begin
          state_d = state_q;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      pwr_meta_q <= 1'b0;
      pwr_sync_q <= 1'b0;
      state_q    <= ST_IDLE;
      seq_cnt_q  <= '0;
      tmo_cnt_q  <= '0;
      retry_q    <= 3'd0;
      fc_init_q  <= 1'b0;
      rdy_q      <= 1'b0;
      err_q      <= 1'b0;
      dft_q      <= LC_OFF;
      esc_q      <= LC_OFF;
      byp_q      <= LC_OFF;
    end else begin
      pwr_meta_q <= cptra_pwrgood;
      pwr_sync_q <= pwr_meta_q;
      state_q    <= state_d;
      seq_cnt_q  <= seq_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      retry_q    <= retry_d;
      fc_init_q  <= fc_init_d;
      rdy_q      <= rdy_d;
      err_q      <= err_d;
      dft_q      <= dft_d;
      esc_q      <= esc_d;
      byp_q      <= byp_d;
    end
  end

  assign fc_partition_init = fc_init_q;
  assign fuse_ctrl_rdy     = rdy_q;
  assign init_err          = err_q;
  assign retry_cnt         = retry_q;
  assign lc_dft_en_i       = dft_q;
  assign lc_escalate_en_i  = esc_q;
  assign lc_check_byp_en_i = byp_q;

endmodule

// File: tb/tb_fuse_ctrl_init_seq.sv
// Event scoreboard bench for fuse_ctrl_init_seq: stimulus predicts each output change
// (cycle + full output snapshot) from the sequencing rules; a monitor pops and compares.
module tb_fuse_ctrl_init_seq;

  localparam int P = 16;
  localparam int T = 4096;
  localparam int R = 2;
  localparam int I = 4;
  localparam logic [3:0] LC_ON  = 4'b0101;
  localparam logic [3:0] LC_OFF = 4'b1010;

  logic core_clk = 1'b0;
  logic core_rst, cptra_pwrgood, otp_lc_data_o_valid, esc_req, check_byp_req, dft_en_req;
  logic fc_partition_init, fuse_ctrl_rdy, init_err;
  logic [3:0] lc_dft_en_i, lc_escalate_en_i, lc_check_byp_en_i;
  logic [2:0] retry_cnt;

  fuse_ctrl_init_seq #(
    .PWRGOOD_STABLE_CYCLES(P), .INIT_TIMEOUT_CYCLES(T),
    .MAX_RETRIES(R), .INIT_PULSE_CYCLES(I)
  ) dut (
    .core_clk(core_clk), .core_rst(core_rst), .cptra_pwrgood(cptra_pwrgood),
    .otp_lc_data_o_valid(otp_lc_data_o_valid), .esc_req(esc_req),
    .check_byp_req(check_byp_req), .dft_en_req(dft_en_req),
    .fc_partition_init(fc_partition_init), .lc_dft_en_i(lc_dft_en_i),
    .lc_escalate_en_i(lc_escalate_en_i), .lc_check_byp_en_i(lc_check_byp_en_i),
    .fuse_ctrl_rdy(fuse_ctrl_rdy), .init_err(init_err), .retry_cnt(retry_cnt)
  );

  always #5 core_clk = ~core_clk;

  int cyc = 0;
  always @(posedge core_clk) cyc <= cyc + 1;

  typedef struct packed {
    logic       fc;
    logic       rdy;
    logic       err;
    logic [2:0] retry;
    logic [3:0] dft;
    logic [3:0] esc;
    logic [3:0] byp;
  } snap_t;

  typedef struct {
    int    at;
    bit    chk;
    snap_t s;
  } exp_t;

  exp_t  q[$];
  snap_t m, last_snap;
  bit    have_last = 1'b0;
  int    last_at = 0;
  int    n_chk = 0, n_pass = 0;
  bit    mon_en = 1'b0;

  function automatic snap_t rst_snap();
    snap_t s;
    s = '0;
    s.dft = LC_OFF;
    s.esc = LC_OFF;
    s.byp = LC_OFF;
    return s;
  endfunction

  // Record the model's current outputs as the expected state from cycle 'at' onward.
  task automatic push(input int at, input bit chk = 1'b1);
    if (!have_last || m != last_snap) begin
      q.push_back('{at, chk, m});
      last_snap = m;
      have_last = 1'b1;
      last_at   = at;
    end
  endtask

  // Monitor: any change in DUT outputs is an event and must match the queue head.
  snap_t cur, prev;
  bit    first = 1'b1;
  exp_t  e;
  always @(negedge core_clk) begin
    if (mon_en) begin
      cur = {fc_partition_init, fuse_ctrl_rdy, init_err, retry_cnt,
             lc_dft_en_i, lc_escalate_en_i, lc_check_byp_en_i};
      if (first || cur != prev) begin
        n_chk++;
        if (q.size() == 0) begin
          $display("FAIL unexpected_event cyc=%0d got=%h", cyc, cur);
        end else begin
          e = q.pop_front();
          if (cur != e.s || (e.chk && e.at != cyc))
            $display("FAIL event cyc=%0d got=%h exp_cyc=%0d exp=%h", cyc, cur, e.at, e.s);
          else
            n_pass++;
        end
        first = 1'b0;
        prev  = cur;
      end else if (q.size() != 0 && q[0].chk && q[0].at < cyc) begin
        n_chk++;
        $display("FAIL missing_event cyc=%0d got=%h exp_cyc=%0d exp=%h", cyc, cur, q[0].at, q[0].s);
        e = q.pop_front();
      end
    end
  end

  task automatic step();
    @(negedge core_clk);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge core_clk);
  endtask

  task automatic settle(input string name);
    wait_cyc(last_at + 2);
    n_chk++;
    if (q.size() != 0)
      $display("FAIL settle_%s cyc=%0d pending=%0d exp_cyc=%0d", name, cyc, q.size(), q[0].at);
    else
      n_pass++;
    q.delete();
  endtask

  task automatic do_reset();
    core_rst = 1'b1;
    cptra_pwrgood = 1'b0; otp_lc_data_o_valid = 1'b0; esc_req = 1'b0;
    check_byp_req = 1'b0; dft_en_req = 1'b0;
    m = rst_snap();
    push(cyc + 1);
    step(); step();
    core_rst = 1'b0;
  endtask

  // Raise power-good (optionally with a one-cycle glitch after gk high cycles).
  // The init pulse starts 2 sync + 1 idle + P cycles after the last rise.
  task automatic start_seq(input int gk, output int r);
    int c, k;
    c = cyc;
    cptra_pwrgood = 1'b1;
    k = gk;
    if (gk < 0) k = ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, P - 1)) : 0;
    if (k > 0) begin
      wait_cyc(c + k);
      cptra_pwrgood = 1'b0;
      step();
      cptra_pwrgood = 1'b1;
      c = cyc;
    end
    r = c + 3 + P;
    m.fc = 1'b1;
    push(r);
  endtask

  // Predict pulse/timeout/retry events; valid arrives d cycles into attempt va (-1: never).
  task automatic run_init(input int r, input int va, input int d);
    int  w, a;
    bit  done;
    w = r + I;
    a = 0;
    done = 1'b0;
    m.fc = 1'b0;
    push(w);
    while (!done) begin
      if (a == va) begin
        wait_cyc(w + d);
        otp_lc_data_o_valid = 1'b1;
        m.rdy = 1'b1;
        push(w + d + 1);
        wait_cyc(w + d + 1);
        done = 1'b1;
      end else if (a < R) begin
        m.retry = 3'(a + 1);
        m.fc = 1'b1;
        push(w + T);
        m.fc = 1'b0;
        push(w + T + I);
        w = w + T + I;
        a++;
      end else begin
        m.err = 1'b1;
        push(w + T);
        wait_cyc(w + T + 1);
        done = 1'b1;
      end
    end
  endtask

  task automatic ready_play(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) dft_en_req = ~dft_en_req;
      if ($urandom_range(0, 3) == 0) check_byp_req = ~check_byp_req;
      otp_lc_data_o_valid = 1'($urandom_range(0, 1));
      m.dft = dft_en_req ? LC_ON : LC_OFF;
      m.byp = check_byp_req ? LC_ON : LC_OFF;
      push(cyc + 1);
      step();
    end
  endtask

  task automatic lose_pwr();
    int c;
    c = cyc;
    cptra_pwrgood = 1'b0;
    m.fc = 1'b0; m.rdy = 1'b0; m.retry = 3'd0;
    m.dft = LC_OFF; m.byp = LC_OFF;
    push(c + 3);
    wait_cyc(c + 4);
    otp_lc_data_o_valid = 1'b0; dft_en_req = 1'b0; check_byp_req = 1'b0;
  endtask

  // Inputs wander freely; terminal states must not produce any output change.
  task automatic noise(input int n);
    for (int i = 0; i < n; i++) begin
      cptra_pwrgood       = 1'($urandom_range(0, 1));
      otp_lc_data_o_valid = 1'($urandom_range(0, 1));
      dft_en_req          = 1'($urandom_range(0, 1));
      check_byp_req       = 1'($urandom_range(0, 1));
      step();
    end
  endtask

  task automatic escalate();
    int c;
    c = cyc;
    esc_req = 1'b1;
    m.esc = LC_ON; m.dft = LC_OFF; m.byp = LC_OFF; m.fc = 1'b0; m.rdy = 1'b0;
    push(c + 1);
    step();
    esc_req = 1'b0;
    noise(20);
  endtask

  initial begin
    #(10 * 100000);
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r, d, sel;
    core_rst = 1'b1;
    cptra_pwrgood = 1'b0; otp_lc_data_o_valid = 1'b0; esc_req = 1'b0;
    check_byp_req = 1'b0; dft_en_req = 1'b0;
    m = rst_snap();
    push(0, 1'b0);
    step(); step();
    mon_en = 1'b1;
    step();
    core_rst = 1'b0;

    // nominal bring-up behind an 8-cycle power-good glitch, then power loss in READY
    start_seq(8, r);
    run_init(r, 0, 10);
    ready_play(30);
    lose_pwr();
    settle("nominal");

    // full rerun after power loss, escalation in READY with bypass requested
    start_seq(0, r);
    run_init(r, 0, int'($urandom_range(0, 50)));
    ready_play(15);
    check_byp_req = 1'b1;
    m.byp = LC_ON;
    push(cyc + 1);
    step(); step();
    escalate();
    settle("esc_ready");
    do_reset();

    // every attempt times out, ERROR ignores power-good and valid, escalation still wins
    start_seq(0, r);
    run_init(r, -1, 0);
    noise(15);
    escalate();
    settle("timeout");
    do_reset();

    // valid in the very last timeout cycle of the second attempt, then reset in READY
    start_seq(0, r);
    run_init(r, 1, T - 1);
    ready_play(10);
    do_reset();
    settle("recovery");

    // power loss and reset while the init pulse is high
    start_seq(0, r);
    wait_cyc(r);
    lose_pwr();
    settle("pulse_loss");
    start_seq(-1, r);
    wait_cyc(r + 1);
    do_reset();
    settle("pulse_reset");

    for (int it = 0; it < 5; it++) begin
      start_seq(-1, r);
      sel = int'($urandom_range(0, 2));
      d = (sel == 0) ? 0 : (sel == 1) ? T - 1 : int'($urandom_range(0, T - 1));
      run_init(r, ($urandom_range(0, 3) == 0) ? 1 : 0, d);
      ready_play(int'($urandom_range(5, 30)));
      sel = int'($urandom_range(0, 2));
      if (sel == 0) begin
        lose_pwr();
      end else if (sel == 1) begin
        escalate();
        settle("rand_esc");
        do_reset();
      end else begin
        do_reset();
      end
      settle("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fuse_ctrl_init_seq.md
# fuse_ctrl_init_seq

Synthesizable sequencer that brings the fuse controller out of power-on: it qualifies power-good, pulses partition initialization, waits for LC data valid with a bounded timeout and retries, then declares the fuse controller ready. It drives the fuse controller's lc_tx_t control inputs (DFT, escalate, check-bypass) from registered, multibit-safe state, so no test-bench forces are needed. It sits between the SoC power/reset logic and the fuse controller, in the core_clk domain.

## Interface
- PWRGOOD_STABLE_CYCLES, 16: consecutive cycles cptra_pwrgood must be high before init starts (≥1).
- INIT_TIMEOUT_CYCLES, 4096: max cycles to wait for otp_lc_data_o_valid per attempt (≥2).
- MAX_RETRIES, 2: re-attempts after a timeout before error (0..7).
- INIT_PULSE_CYCLES, 4: width of fc_partition_init pulse (≥1).

Ports:
- core_clk  in  1  clock.
- core_rst  in  1  synchronous, active-high reset.
- cptra_pwrgood  in  1  power-good, asynchronous to core_clk; 2-flop synchronized internally.
- otp_lc_data_o_valid  in  1  fuse controller LC data valid (level).
- esc_req  in  1  escalation request, sampled every cycle.
- check_byp_req  in  1  request LC check bypass; honored only in READY.
- dft_en_req  in  1  request DFT enable; honored only in READY.
- fc_partition_init  out  1  partition init request to fuse controller.
- lc_dft_en_i  out  lc_tx_t  DFT enable to fuse controller.
- lc_escalate_en_i  out  lc_tx_t  escalation to fuse controller.
- lc_check_byp_en_i  out  lc_tx_t  check bypass to fuse controller.
- fuse_ctrl_rdy  out  1  initialization complete.
- init_err  out  1  sticky: all attempts timed out.
- retry_cnt  out  3  attempts consumed so far.

## Operation
- lc_tx_t encodings come from lc_ctrl_pkg: On = 4'b0101, Off = 4'b1010; all three lc outputs are flops loaded only with On or Off.
- States: IDLE, PWR_QUAL, INIT_PULSE, WAIT_VALID, READY, ERROR, ESCALATED.
- IDLE: wait for synchronized pwrgood = 1, then go to PWR_QUAL with stable counter cleared.
- PWR_QUAL: count while pwrgood is high; a low cycle returns to IDLE. At count = PWRGOOD_STABLE_CYCLES-1, go to INIT_PULSE.
- INIT_PULSE: fc_partition_init = 1 for exactly INIT_PULSE_CYCLES, then go to WAIT_VALID with the timeout counter cleared.
- WAIT_VALID: if otp_lc_data_o_valid = 1, go to READY. If the timeout counter reaches INIT_TIMEOUT_CYCLES-1 without valid, then: if retry_cnt < MAX_RETRIES, increment retry_cnt and go to INIT_PULSE; otherwise go to ERROR.
- READY: fuse_ctrl_rdy = 1. lc_check_byp_en_i = On iff check_byp_req; lc_dft_en_i = On iff dft_en_req; both update one cycle after the request. Deassertion of valid in READY does not leave READY.
- ERROR: init_err = 1, fuse_ctrl_rdy = 0, fc_partition_init = 0. Terminal until core_rst.
- Loss of synchronized pwrgood in PWR_QUAL, INIT_PULSE, WAIT_VALID or READY returns to IDLE. This clears fuse_ctrl_rdy, retry_cnt, lc_dft_en_i and lc_check_byp_en_i (→Off) and drops fc_partition_init. ERROR and ESCALATED ignore pwrgood.
- esc_req = 1 in any state, highest priority, moves to ESCALATED. In ESCALATED: lc_escalate_en_i = On, lc_dft_en_i = Off, lc_check_byp_en_i = Off, fc_partition_init = 0, fuse_ctrl_rdy = 0. Sticky until core_rst.
- Priority for same-cycle events: esc_req > pwrgood loss > valid > timeout.
- Valid arriving in the last timeout cycle counts as success.

## Timing
- Reset values: fc_partition_init 0, lc_* Off, fuse_ctrl_rdy 0, init_err 0, retry_cnt 0, state IDLE, counters 0.
- All outputs are registered; no combinational path from input to output.
- pwrgood latency: 2 sync cycles + 1 IDLE cycle + PWRGOOD_STABLE_CYCLES, then fc_partition_init rises.
- fuse_ctrl_rdy rises 1 cycle after valid is sampled in WAIT_VALID.
- esc_req to lc_escalate_en_i = On: 1 cycle.
- Timeout counter width is $clog2(INIT_TIMEOUT_CYCLES); the counter never wraps and holds until the state exits.
- core_rst asserted mid-sequence returns to reset values on the next edge.

## Test plan
- Nominal (defaults): pwrgood high, valid 10 cycles after the pulse ends -> fc_partition_init high exactly 4 cycles, fuse_ctrl_rdy 1 cycle after valid, init_err 0, retry_cnt 0.
- Pwrgood glitch: high 8 cycles, low 1, then high -> no init pulse until 16 consecutive high cycles.
- Timeout with retries: valid never asserted -> 3 init pulses, each 4096 cycles apart in WAIT_VALID, retry_cnt ends at 2, then init_err = 1 and fc_partition_init stays 0.
- Recovery on retry: valid asserted during the 2nd attempt -> retry_cnt = 1, fuse_ctrl_rdy = 1, init_err = 0.
- Escalation in READY with check_byp_req = 1 -> next cycle lc_escalate_en_i = 4'b0101, lc_check_byp_en_i = 4'b1010, fuse_ctrl_rdy = 0; state holds after esc_req drops and pwrgood toggles.
- Pwrgood loss in READY -> fuse_ctrl_rdy 0 and lc_dft_en_i Off; when pwrgood returns, the full sequence reruns with retry_cnt = 0.
